// File: rtl/seq_alu_acc_if.sv
// Valid/ready operand and result bundle between the operand stage,
// the sequential ALU and the result bus.
interface seq_alu_acc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             a_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_e;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a_sel, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_e, acc
  );

  modport slave (
    input  in_valid, op, a_sel, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_e, acc
  );
endinterface

// File: rtl/seq_alu_acc.sv
// Registered ALU with accumulator: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, behind valid/ready handshakes.
module seq_alu_acc #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
) (
  input  logic         clk,
  input  logic         rst,
  seq_alu_acc_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_NAND = 4'd3,
    OP_OR   = 4'd4,
    OP_NOR  = 4'd5,
    OP_XOR  = 4'd6,
    OP_XNOR = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIV  = 4'd11,
    OP_REM  = 4'd12,
    OP_PASS = 4'd13,
    OP_CLR  = 4'd14,
    OP_RSV  = 4'd15
  } op_t;

  state_t           state_q;
  op_t              calcOp_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] shiftA_q;
  logic [WIDTH-1:0] shiftB_q;
  logic [WIDTH:0]   work_q;
  logic [CW-1:0]    count_q;
  logic             flagZ_q;
  logic             flagC_q;
  logic             flagE_q;

  op_t              opIn;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [SHW-1:0]   shAmt;
  logic [WIDTH:0]   sumExt;
  logic [WIDTH-1:0] quickRes;
  logic             quickC;
  logic             quickE;
  logic             isIter;

  always_comb begin
    opIn     = op_t'(bus.op);
    opA      = bus.a_sel ? acc_q : bus.a;
    opB      = bus.b;
    shAmt    = opB[SHW-1:0];
    sumExt   = {1'b0, opA} + {1'b0, opB};
    quickRes = '0;
    quickC   = 1'b0;
    quickE   = 1'b0;
    isIter   = 1'b0;
    case (opIn)
      OP_ADD: begin
        quickRes = sumExt[WIDTH-1:0];
        quickC   = sumExt[WIDTH];
      end
      OP_SUB: begin
        quickRes = opA - opB;
        quickC   = (opA < opB);
      end
      OP_AND:  quickRes = opA & opB;
      OP_NAND: quickRes = ~(opA & opB);
      OP_OR:   quickRes = opA | opB;
      OP_NOR:  quickRes = ~(opA | opB);
      OP_XOR:  quickRes = opA ^ opB;
      OP_XNOR: quickRes = ~(opA ^ opB);
      OP_SHL:  quickRes = opA << shAmt;
      OP_SHR:  quickRes = opA >> shAmt;
      // A zero B short-circuits the iterative ops straight to DONE
      OP_MUL:  isIter = (opB != '0);
      OP_DIV: begin
        if (opB == '0) begin
          quickRes = '1;
          quickE   = 1'b1;
        end else begin
          isIter = 1'b1;
        end
      end
      OP_REM: begin
        if (opB == '0) begin
          quickRes = opA;
          quickE   = 1'b1;
        end else begin
          isIter = 1'b1;
        end
      end
      OP_PASS: quickRes = opA;
      OP_CLR:  quickRes = '0;
      default: quickE = 1'b1;
    endcase
  end

  // MUL: work = partial product, shiftA = multiplicand, shiftB = multiplier.
  // DIV/REM: work = partial remainder, shiftA = dividend -> quotient, shiftB = divisor.
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remSub;
  logic [WIDTH:0]   iterWork;
  logic [WIDTH-1:0] iterA;
  logic [WIDTH-1:0] iterB;
  logic [WIDTH-1:0] calcRes;

  always_comb begin
    iterWork = work_q;
    iterA    = shiftA_q;
    iterB    = shiftB_q;
    remShift = {work_q[WIDTH-1:0], shiftA_q[WIDTH-1]};
    remSub   = remShift - {1'b0, shiftB_q};
    if (calcOp_q == OP_MUL) begin
      if (shiftB_q[0]) begin
        iterWork = {1'b0, work_q[WIDTH-1:0] + shiftA_q};
      end
      iterA = shiftA_q << 1;
      iterB = shiftB_q >> 1;
    end else begin
      if (remShift >= {1'b0, shiftB_q}) begin
        iterWork = remSub;
        iterA    = {shiftA_q[WIDTH-2:0], 1'b1};
      end else begin
        iterWork = remShift;
        iterA    = {shiftA_q[WIDTH-2:0], 1'b0};
      end
    end
    calcRes = (calcOp_q == OP_DIV) ? iterA : iterWork[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      calcOp_q <= OP_ADD;
      result_q <= '0;
      acc_q    <= '0;
      shiftA_q <= '0;
      shiftB_q <= '0;
      work_q   <= '0;
      count_q  <= '0;
      flagZ_q  <= 1'b0;
      flagC_q  <= 1'b0;
      flagE_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (isIter) begin
              state_q  <= CALC;
              calcOp_q <= opIn;
              work_q   <= '0;
              shiftA_q <= opA;
              shiftB_q <= opB;
              count_q  <= '0;
            end else begin
              state_q  <= DONE;
              result_q <= quickRes;
              flagZ_q  <= (quickRes == '0);
              flagC_q  <= quickC;
              flagE_q  <= quickE;
              if (opIn != OP_RSV) begin
                acc_q <= quickRes;
              end
            end
          end
        end
        CALC: begin
          work_q   <= iterWork;
          shiftA_q <= iterA;
          shiftB_q <= iterB;
          count_q  <= count_q + CW'(1);
          // The last iteration's combinational result is registered directly
          if (count_q == CW'(WIDTH - 1)) begin
            state_q  <= DONE;
            result_q <= calcRes;
            acc_q    <= calcRes;
            flagZ_q  <= (calcRes == '0);
            flagC_q  <= 1'b0;
            flagE_q  <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flag_z    = flagZ_q;
  assign bus.flag_c    = flagC_q;
  assign bus.flag_e    = flagE_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_seq_alu_acc.sv
// Directed bench for seq_alu_acc (WIDTH=16): hand-computed vectors covering
// every op class, latency, backpressure, accumulator chaining and mid-op reset.
module tb_seq_alu_acc;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  seq_alu_acc_if #(.WIDTH(WIDTH)) bus ();

  seq_alu_acc #(.WIDTH(WIDTH), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one op, waits for the accept edge, then scrambles the operand
  // inputs and counts cycles until out_valid.
  task automatic applyStimulus(input logic [3:0] opc, input logic aSel,
                               input logic [15:0] aVal, input logic [15:0] bVal,
                               output int latency, output logic readySeen);
    int guard;
    @(negedge clk);
    bus.op       = opc;
    bus.a_sel    = aSel;
    bus.a        = aVal;
    bus.b        = bVal;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 4'd14;
    bus.a        = ~aVal;
    bus.b        = bVal ^ 16'h5A5A;
    latency   = 1;
    readySeen = 1'b0;
    while (!bus.out_valid && latency < 100) begin
      if (bus.in_ready) readySeen = 1'b1;
      @(posedge clk);
      #1;
      latency++;
    end
    if (bus.in_ready) readySeen = 1'b1;
  endtask

  task automatic takeResult();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [3:0] opc, input logic aSel,
                           input logic [15:0] aVal, input logic [15:0] bVal,
                           input logic [15:0] expRes, input logic expZ, input logic expC,
                           input logic expE, input logic [15:0] expAcc, input int expLat);
    int   lat;
    logic rdy;
    applyStimulus(opc, aSel, aVal, bVal, lat, rdy);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " result"}, bus.result, expRes);
    checkOutput({tag, " flag_z"}, bus.flag_z, expZ);
    checkOutput({tag, " flag_c"}, bus.flag_c, expC);
    checkOutput({tag, " flag_e"}, bus.flag_e, expE);
    checkOutput({tag, " acc"}, bus.acc, expAcc);
    checkOutput({tag, " in_ready busy"}, rdy, 1'b0);
    takeResult();
    checkOutput({tag, " out_valid after take"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    logic rdy;
    checkCount    = 0;
    failCount     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a_sel     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    #1;
    checkOutput("reset out_valid", bus.out_valid, 1'b0);
    checkOutput("reset in_ready", bus.in_ready, 1'b0);
    checkOutput("reset result", bus.result, 16'h0000);
    checkOutput("reset acc", bus.acc, 16'h0000);
    checkOutput("reset flags", {bus.flag_z, bus.flag_c, bus.flag_e}, 3'b000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle in_ready", bus.in_ready, 1'b1);

    //          tag          op    sel a         b         res       z     c     e     acc       lat
    runVector("ADD wrap",    4'd0,  0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1);
    runVector("SHL",         4'd8,  0, 16'h000B, 16'h0005, 16'h0160, 1'b0, 1'b0, 1'b0, 16'h0160, 1);
    runVector("SHR by 16",   4'd9,  0, 16'h8000, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1);
    runVector("SUB borrow",  4'd1,  0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1);
    runVector("AND",         4'd2,  0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 16'h3030, 1);
    runVector("NOR",         4'd5,  0, 16'h0F00, 16'h00F0, 16'hF00F, 1'b0, 1'b0, 1'b0, 16'hF00F, 1);
    runVector("XNOR",        4'd7,  0, 16'hAAAA, 16'hFFFF, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'hAAAA, 1);
    runVector("MUL",         4'd10, 0, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b0, 1'b0, 16'h5F90, 17);
    runVector("DIV",         4'd11, 0, 16'd1000, 16'd7,    16'h008E, 1'b0, 1'b0, 1'b0, 16'h008E, 17);
    runVector("REM",         4'd12, 0, 16'd1000, 16'd7,    16'h0006, 1'b0, 1'b0, 1'b0, 16'h0006, 17);
    runVector("DIV by zero", 4'd11, 0, 16'd5,    16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1);
    runVector("reserved",    4'd15, 0, 16'h1234, 16'h4321, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1);
    runVector("CLR",         4'd14, 0, 16'h1234, 16'h4321, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1);
    runVector("PASS",        4'd13, 0, 16'h0005, 16'h7777, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0005, 1);
    runVector("ADD acc 1",   4'd0,  1, 16'h7777, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0008, 1);

    applyStimulus(4'd0, 1'b1, 16'h7777, 16'h0003, lat, rdy);
    checkOutput("ADD acc 2 latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("backpressure result", bus.result, 16'h000B);
      checkOutput("backpressure acc", bus.acc, 16'h000B);
      checkOutput("backpressure flags", {bus.flag_z, bus.flag_c, bus.flag_e}, 3'b000);
      checkOutput("backpressure out_valid", bus.out_valid, 1'b1);
      checkOutput("backpressure in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    takeResult();
    checkOutput("ADD acc 2 released", bus.out_valid, 1'b0);

    @(negedge clk);
    bus.op       = 4'd10;
    bus.a_sel    = 1'b0;
    bus.a        = 16'd300;
    bus.b        = 16'd300;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid-MUL reset out_valid", bus.out_valid, 1'b0);
    checkOutput("mid-MUL reset acc", bus.acc, 16'h0000);
    checkOutput("mid-MUL reset result", bus.result, 16'h0000);
    checkOutput("mid-MUL reset in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    runVector("ADD after reset", 4'd0, 0, 16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0004, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
